// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_rr_arbiter
//  Brief    : Round-robin arbiter sharing one Wishbone classic slave port
//             between NUM_MASTERS masters. It holds the grant for the whole
//             cyc window and has a watchdog that aborts slave cycles that
//             never respond.
//  Revision : 1.0  initial release
// ============================================================================
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  // master side
  input  logic [NUM_MASTERS-1:0]      m_cyc,
  input  logic [NUM_MASTERS-1:0]      m_stb,
  input  logic [NUM_MASTERS-1:0]      m_we,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_w,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel,
  output logic [NUM_MASTERS-1:0]      m_ack,
  output logic [NUM_MASTERS-1:0]      m_err,
  output logic [DW-1:0]               m_dat_r,
  // slave side
  output logic                        s_cyc,
  output logic                        s_stb,
  output logic                        s_we,
  output logic [AW-1:0]               s_adr,
  output logic [DW-1:0]               s_dat_w,
  output logic [DW/8-1:0]             s_sel,
  input  logic                        s_ack,
  input  logic                        s_err,
  input  logic [DW-1:0]               s_dat_r,
  // current owner
  output logic [NUM_MASTERS-1:0]      grant
);

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [GW-1:0]          g, g_n;
  logic [GW-1:0]          rr_ptr, rr_ptr_n;
  logic [NUM_MASTERS-1:0] grant_n;

  logic [GW-1:0]          pick;
  logic                   pick_valid;
  logic                   wd_hit;

  // Per-master views of the packed buses, so the owner can be selected by index.
  logic [AW-1:0] adr_arr   [NUM_MASTERS];
  logic [DW-1:0] dat_w_arr [NUM_MASTERS];
  logic [SW-1:0] sel_arr   [NUM_MASTERS];

  generate
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
      assign adr_arr[i]   = m_adr[i*AW +: AW];
      assign dat_w_arr[i] = m_dat_w[i*DW +: DW];
      assign sel_arr[i]   = m_sel[i*SW +: SW];
    end
  endgenerate

  // Read data needs no routing: every master sees it and only the owner gets ack.
  assign m_dat_r = s_dat_r;

  // Wrap with an explicit compare so non-power-of-2 master counts stay in range.
  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] i);
    if (i == GW'(NUM_MASTERS - 1)) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  // Round-robin scan of m_cyc starting at rr_ptr.
  always_comb begin
    logic [GW-1:0] idx;
    pick       = '0;
    pick_valid = 1'b0;
    idx        = rr_ptr;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!pick_valid && m_cyc[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
      idx = next_idx(idx);
    end
  end

  // Watchdog: counts consecutive waiting strobe cycles of the owner.
  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int WDW = $clog2(TIMEOUT + 1);
      logic [WDW-1:0] wd_cnt;
      logic           wd_wait;

      assign wd_wait = (state == ST_BUSY) && s_stb && !s_ack && !s_err;
      // The abort fires on the edge at which the count reaches TIMEOUT.
      assign wd_hit  = wd_wait && (wd_cnt >= WDW'(TIMEOUT - 1));

      // Saturating wait counter; any response, idle strobe or non-BUSY state clears it.
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          wd_cnt <= '0;
        end else if (wd_wait) begin
          if (wd_cnt != WDW'(TIMEOUT)) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end else begin
          wd_cnt <= '0;
        end
      end
    end else begin : g_no_wd
      assign wd_hit = 1'b0;
    end
  endgenerate

  // State, owner index, grant vector and round-robin pointer.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state  <= ST_IDLE;
      g      <= '0;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      g      <= g_n;
      grant  <= grant_n;
      rr_ptr <= rr_ptr_n;
    end
  end

  // Next-state logic plus slave mux and response routing.
  always_comb begin
    state_n  = state;
    g_n      = g;
    grant_n  = grant;
    rr_ptr_n = rr_ptr;
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_w  = '0;
    s_sel    = '0;
    m_ack    = '0;
    m_err    = '0;

    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          g_n     = pick;
          grant_n = NUM_MASTERS'(1) << pick;
          state_n = ST_BUSY;
        end
      end

      ST_BUSY: begin
        s_cyc    = m_cyc[g];
        s_stb    = m_stb[g];
        s_we     = m_we[g];
        s_adr    = adr_arr[g];
        s_dat_w  = dat_w_arr[g];
        s_sel    = sel_arr[g];
        // ack and err pass through together; masters resolve err first.
        m_ack[g] = s_ack;
        m_err[g] = s_err;
        if (!m_cyc[g]) begin
          state_n  = ST_IDLE;
          grant_n  = '0;
          rr_ptr_n = next_idx(g);
        end else if (wd_hit) begin
          state_n  = ST_ABORT;
        end
      end

      ST_ABORT: begin
        // Slave side is dropped; the owner gets a single synthetic error.
        m_err[g] = 1'b1;
        state_n  = ST_DRAIN;
      end

      ST_DRAIN: begin
        // Wait for the aborted owner to finish its cyc before re-arbitrating.
        if (!m_cyc[g]) begin
          state_n  = ST_IDLE;
          grant_n  = '0;
          rr_ptr_n = next_idx(g);
        end
      end

      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
      end
    endcase
  end

endmodule
`default_nettype wire
